mux_key: RTL and testbench



---
 rtl/mux_key.sv | 52 +++++
 tb/tb_mux_key.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_key.sv
// Key-lookup multiplexer: selects the data of the pair whose key matches the lookup key.
// The highest-index match wins. Registered copies of the result and hit flag are provided.
module mux_key #(
   parameter int                   NR_KEY      = 2,
   parameter int                   KEY_LEN     = 1,
   parameter int                   DATA_LEN    = 1,
   parameter logic [DATA_LEN-1:0]  DEFAULT_OUT = '0
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [KEY_LEN-1:0]                    key,
   input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
   output logic [DATA_LEN-1:0]                   out,
   output logic                                  hit,
   output logic [DATA_LEN-1:0]                   out_q,
   output logic                                  hit_q
);

   localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

   logic [NR_KEY-1:0] match;

   always_comb begin
      for (int i = 0; i < NR_KEY; i++) begin
         match[i] = (lut[PAIR_LEN*i+DATA_LEN +: KEY_LEN] == key);
      end
   end

   // Ascending scan so a later (higher-index) match overrides an earlier one:
   // the pair written first in the concatenation has priority.
   always_comb begin
      out = DEFAULT_OUT;
      hit = 1'b0;
      for (int i = 0; i < NR_KEY; i++) begin
         if (match[i]) begin
            out = lut[PAIR_LEN*i +: DATA_LEN];
            hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
         hit_q <= 1'b0;
      end else begin
         out_q <= out;
         hit_q <= hit;
      end
   end

endmodule

// File: tb/tb_mux_key.sv
// Bench for mux_key: a 5x(3+32) instance driven with directed and random tables/keys,
// plus a minimal 1x(1+1) instance. Results come from a priority-search model.
module tb_mux_key;

   localparam int NR = 5;
   localparam int KL = 3;
   localparam int DL = 32;
   localparam int LW = NR * (KL + DL);

   logic          clk;
   logic          rst_n;
   logic [KL-1:0] key;
   logic [LW-1:0] lut;
   logic [DL-1:0] out, out_q;
   logic          hit, hit_q;

   logic          key1;
   logic [1:0]    lut1;
   logic          out1, out1_q, hit1, hit1_q;

   logic [KL-1:0] tkey [NR];
   logic [DL-1:0] tdat [NR];

   logic [DL:0]   exp_q [$];
   int            n_checks;
   int            n_fail;
   logic          done;

   mux_key #(.NR_KEY(NR), .KEY_LEN(KL), .DATA_LEN(DL), .DEFAULT_OUT(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .key(key), .lut(lut),
      .out(out), .hit(hit), .out_q(out_q), .hit_q(hit_q)
   );

   mux_key #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1), .DEFAULT_OUT(1'b0)) dut_min (
      .clk(clk), .rst_n(rst_n), .key(key1), .lut(lut1),
      .out(out1), .hit(hit1), .out_q(out1_q), .hit_q(hit1_q)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Search from the first-written pair (highest index) downwards; first hit wins.
   function automatic logic [DL:0] ref_lookup(input logic [KL-1:0] k);
      for (int i = NR - 1; i >= 0; i--) begin
         if (tkey[i] == k) return {1'b1, tdat[i]};
      end
      return {1'b0, 32'h0};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   always @(posedge clk) begin
      exp_q.push_back(rst_n ? ref_lookup(key) : {(DL+1){1'b0}});
   end

   always @(negedge clk) begin
      logic [DL:0] m;
      logic [DL:0] r;
      if (!done) begin
         m = ref_lookup(key);
         check("out", 64'(out), 64'(m[DL-1:0]));
         check("hit", 64'(hit), 64'(m[DL]));
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL exp_q_empty actual=0 expected=1");
         end else begin
            r = exp_q.pop_front();
            if (!rst_n) r = '0;
            check("out_q", 64'(out_q), 64'(r[DL-1:0]));
            check("hit_q", 64'(hit_q), 64'(r[DL]));
         end
         check("min_hit", 64'(hit1), 64'(lut1[1] == key1));
         check("min_out", 64'(out1), 64'((lut1[1] == key1) ? lut1[0] : 1'b0));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic pack_lut();
      lut = '0;
      for (int i = NR - 1; i >= 0; i--) lut = {lut[LW-KL-DL-1:0], tkey[i], tdat[i]};
   endtask

   task automatic load_base();
      lut = {3'b000, 32'h11111111, 3'b001, 32'h22222222, 3'b010, 32'h33333333,
             3'b011, 32'h44444444, 3'b100, 32'h55555555};
      for (int j = 0; j < NR; j++) begin
         tkey[NR-1-j] = KL'(j);
         tdat[NR-1-j] = 32'h11111111 * (j + 1);
      end
   endtask

   task automatic random_table();
      for (int i = 0; i < NR; i++) begin
         tkey[i] = KL'($urandom_range(0, 7));
         tdat[i] = $urandom;
      end
      pack_lut();
   endtask

   // ---------------- stimulus ----------------
   logic [DL-1:0] sweep_exp [5];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      done     = 1'b0;
      rst_n    = 1'b0;
      key      = '0;
      key1     = 1'b0;
      lut1     = 2'b11;
      load_base();
      #1;
      check("reset_out_q", 64'(out_q), 64'h0);
      check("reset_hit_q", 64'(hit_q), 64'h0);
      step();
      step();
      rst_n = 1'b1;

      // Pin the model against hand values
      check("model_k3", 64'(ref_lookup(3'd3)), {31'h0, 1'b1, 32'h44444444});
      check("model_k6", 64'(ref_lookup(3'd6)), 64'h0);

      sweep_exp[0] = 32'h11111111; sweep_exp[1] = 32'h22222222; sweep_exp[2] = 32'h33333333;
      sweep_exp[3] = 32'h44444444; sweep_exp[4] = 32'h55555555;
      for (int k = 0; k < 5; k++) begin
         step();
         key = KL'(k);
         #1;
         check("sweep_out", 64'(out), 64'(sweep_exp[k]));
         check("sweep_hit", 64'(hit), 64'h1);
      end
      step();
      #1;
      check("sweep_out_q", 64'(out_q), 64'h55555555);
      check("sweep_hit_q", 64'(hit_q), 64'h1);

      for (int k = 5; k < 8; k++) begin
         key = KL'(k);
         #1;
         check("miss_out", 64'(out), 64'h0);
         check("miss_hit", 64'(hit), 64'h0);
         step();
         #1;
         check("miss_out_q", 64'(out_q), 64'h0);
         check("miss_hit_q", 64'(hit_q), 64'h0);
      end

      // Duplicate keys: first-written pair wins
      lut = {3'b010, 32'hAAAAAAAA, 3'b010, 32'hBBBBBBBB, 3'b000, 32'h11111111,
             3'b001, 32'h22222222, 3'b100, 32'h55555555};
      tkey[4] = 3'b010; tdat[4] = 32'hAAAAAAAA;
      tkey[3] = 3'b010; tdat[3] = 32'hBBBBBBBB;
      tkey[2] = 3'b000; tdat[2] = 32'h11111111;
      tkey[1] = 3'b001; tdat[1] = 32'h22222222;
      tkey[0] = 3'b100; tdat[0] = 32'h55555555;
      key = 3'b010;
      #1;
      check("dup_out", 64'(out), 64'hAAAAAAAA);
      check("dup_hit", 64'(hit), 64'h1);

      // Asynchronous reset between edges
      step();
      load_base();
      key = 3'b001;
      step();
      #1;
      check("pre_rst_out_q", 64'(out_q), 64'h22222222);
      rst_n = 1'b0;
      #1;
      check("rst_out_q", 64'(out_q), 64'h0);
      check("rst_hit_q", 64'(hit_q), 64'h0);
      check("rst_out_live", 64'(out), 64'h22222222);
      check("rst_hit_live", 64'(hit), 64'h1);
      step();
      rst_n = 1'b1;
      #1;
      check("rel_out_q_hold", 64'(out_q), 64'h0);
      step();
      #1;
      check("rel_out_q", 64'(out_q), 64'h22222222);
      check("rel_hit_q", 64'(hit_q), 64'h1);

      // Minimal configuration
      lut1 = 2'b11;
      key1 = 1'b1;
      #1;
      check("min_k1_out", 64'(out1), 64'h1);
      check("min_k1_hit", 64'(hit1), 64'h1);
      key1 = 1'b0;
      #1;
      check("min_k0_out", 64'(out1), 64'h0);
      check("min_k0_hit", 64'(hit1), 64'h0);

      // Randomized phase
      random_table();
      for (int c = 0; c < 400; c++) begin
         step();
         if ($urandom_range(0, 19) == 0) random_table();
         key  = KL'($urandom_range(0, 7));
         key1 = 1'($urandom_range(0, 1));
         lut1 = 2'($urandom_range(0, 3));
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 29) == 0) rst_n = 1'b0;
      end
      rst_n = 1'b1;
      step();
      step();
      @(negedge clk);
      #1;
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
